board_io_ctrl: RTL and testbench
================================

BOARD_IO_CTRL -- requirements
Module: board_io_ctrl

Interface
REQ-001 SHALL have parameter NUM_SW, default 18: number of board slide switches handled.
REQ-002 SHALL have parameter NUM_HEX, default 8: number of 7-segment digits driven.
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 270000: clk_i cycles per debounce sample tick (10 ms at 27 MHz), legal range >= 2.
REQ-004 SHALL have parameter BLINK_CYC, default 13500000: clk_i cycles per blink phase toggle, legal range >= 2.
REQ-005 SHALL have port clk_i, input, 1: single system clock; all state on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port sw_raw_i, input, NUM_SW: raw asynchronous switch levels.
REQ-008 SHALL have port sw_o, output, NUM_SW: debounced switch levels.
REQ-009 SHALL have port sw_rise_o, output, NUM_SW: one-cycle pulse on each debounced 0->1 change.
REQ-010 SHALL have port hex_val_i, input, 4*NUM_HEX: hex nibble per digit, digit k at bits [4k+3:4k].
REQ-011 SHALL have port hex_en_i, input, NUM_HEX: digit enable, 0 = blank.
REQ-012 SHALL have port hex_blink_i, input, NUM_HEX: digit blinks when 1.
REQ-013 SHALL have port hex_o, output, 7*NUM_HEX: active-low segments, digit k at bits [7k+6:7k], bit order g..a from MSB to LSB.
REQ-014 SHALL have port core_rst_no, output, 1: synchronised active-low reset for the downstream core.

Function
REQ-015 SHALL pass each sw_raw_i bit through a two-flop synchroniser before any other use.
REQ-016 SHALL use one shared tick counter counting 0..DEBOUNCE_CYC-1, wrapping to 0, with a tick asserted for one cycle when the count equals DEBOUNCE_CYC-1.
REQ-017 SHALL keep a 2-bit disagreement count per switch, updated only on tick cycles.
REQ-018 On tick, where synchronised bit equals sw_o, SHALL clear that switch's count.
REQ-019 On tick, where synchronised bit differs from sw_o and the count is below 2, SHALL increment the count.
REQ-020 On tick, where synchronised bit differs from sw_o and the count equals 2, SHALL load sw_o from the synchronised bit and clear the count, so three consecutive differing ticks are needed.
REQ-021 SHALL assert sw_rise_o[i] for exactly the cycle after sw_o[i] changes 0->1, with no pulse on 1->0 changes.
REQ-022 SHALL toggle a blink phase bit every BLINK_CYC cycles from a dedicated wrapping counter.
REQ-023 SHALL drive digit k blank (all segments 1) when hex_en_i[k]=0, or when hex_blink_i[k]=1 and the blink phase is 1.
REQ-024 Otherwise SHALL drive digit k with the standard 0-F decode, active-low (for example 0 -> 7'b1000000, 8 -> 7'b0000000, F -> 7'b0001110).
REQ-025 SHALL register hex_o, giving exactly one cycle of latency from hex_val_i, hex_en_i and hex_blink_i to hex_o.
REQ-026 SHALL assert core_rst_no low asynchronously with rst_ni, and release it high on the second rising clk_i edge after rst_ni goes high.

Reset
REQ-027 While rst_ni=0, SHALL hold sw_o=0, sw_rise_o=0, hex_o all 1, core_rst_no=0, and all counters, synchronisers and the blink phase at 0.
REQ-028 Reset asserted mid-debounce or mid-blink SHALL discard all progress, and counting SHALL restart from 0 after release.
REQ-029 No pulse on sw_rise_o SHALL result from reset entry or exit alone.

Verification (DEBOUNCE_CYC=4, BLINK_CYC=8, NUM_SW=2, NUM_HEX=2)
REQ-030 Release rst_ni -> core_rst_no=0 after the first edge and 1 after the second; hex_o=14'h3FFF until the first registered update.
REQ-031 Hold sw_raw_i[0]=1 steadily -> sw_o[0]=1 on the third tick after synchronisation, with sw_rise_o[0]=1 for exactly one cycle.
REQ-032 Toggle sw_raw_i[1] with a 1-tick high glitch, then 2 ticks high, then low -> sw_o[1] stays 0 and sw_rise_o[1] stays 0.
REQ-033 hex_val_i=8'hF0, hex_en_i=2'b11, hex_blink_i=0 -> next cycle hex_o = {7'b0001110, 7'b1000000}.
REQ-034 hex_blink_i=2'b01 -> digit 0 alternates between the decode and 7'h7F every 8 cycles, while digit 1 stays constant.
REQ-035 Assert rst_ni low with sw_o[0]=1 and a count of 2 pending -> all outputs immediately take their reset values and core_rst_no=0, without waiting for a clock edge.

Source files
------------

// File: rtl/board_io_ctrl.sv
// rtl/board_io_ctrl.sv - board switch debouncer, 7-segment driver and core reset synchroniser
module board_io_ctrl #(
  parameter int NUM_SW       = 18,
  parameter int NUM_HEX      = 8,
  parameter int DEBOUNCE_CYC = 270000,
  parameter int BLINK_CYC    = 13500000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NUM_SW-1:0]    sw_raw_i,
  output logic [NUM_SW-1:0]    sw_o,
  output logic [NUM_SW-1:0]    sw_rise_o,
  input  logic [4*NUM_HEX-1:0] hex_val_i,
  input  logic [NUM_HEX-1:0]   hex_en_i,
  input  logic [NUM_HEX-1:0]   hex_blink_i,
  output logic [7*NUM_HEX-1:0] hex_o,
  output logic                 core_rst_no
);

  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int BW = $clog2(BLINK_CYC);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYC - 1);

  logic [NUM_SW-1:0]        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [NUM_SW-1:0]        sw_q, sw_d, rise_q, rise_d;
  logic [NUM_SW-1:0][1:0]   dis_cnt_q, dis_cnt_d;
  logic [DW-1:0]            db_cnt_q, db_cnt_d;
  logic [BW-1:0]            bl_cnt_q, bl_cnt_d;
  logic                     phase_q, phase_d;
  logic [7*NUM_HEX-1:0]     hex_q, hex_d;
  logic [1:0]               core_q, core_d;
  logic                     db_tick;
  logic                     bl_tick;

  // Active-low segments, bit order g..a.
  function automatic logic [6:0] seg_lut(input logic [3:0] v);
    case (v)
      4'h0: seg_lut = 7'b1000000;
      4'h1: seg_lut = 7'b1111001;
      4'h2: seg_lut = 7'b0100100;
      4'h3: seg_lut = 7'b0110000;
      4'h4: seg_lut = 7'b0011001;
      4'h5: seg_lut = 7'b0010010;
      4'h6: seg_lut = 7'b0000010;
      4'h7: seg_lut = 7'b1111000;
      4'h8: seg_lut = 7'b0000000;
      4'h9: seg_lut = 7'b0010000;
      4'hA: seg_lut = 7'b0001000;
      4'hB: seg_lut = 7'b0000011;
      4'hC: seg_lut = 7'b1000110;
      4'hD: seg_lut = 7'b0100001;
      4'hE: seg_lut = 7'b0000110;
      default: seg_lut = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    sync1_d   = sw_raw_i;
    sync2_d   = sync1_q;
    sw_d      = sw_q;
    dis_cnt_d = dis_cnt_q;
    db_tick   = (db_cnt_q == DB_LAST);
    db_cnt_d  = db_tick ? '0 : db_cnt_q + DW'(1);
    bl_tick   = (bl_cnt_q == BL_LAST);
    bl_cnt_d  = bl_tick ? '0 : bl_cnt_q + BW'(1);
    phase_d   = bl_tick ? ~phase_q : phase_q;
    core_d    = {core_q[0], 1'b1};
    hex_d     = '1;

    // A switch only follows its synchronised input after three differing ticks in a row.
    if (db_tick) begin
      for (int i = 0; i < NUM_SW; i++) begin
        if (sync2_q[i] == sw_q[i]) begin
          dis_cnt_d[i] = 2'd0;
        end else if (dis_cnt_q[i] == 2'd2) begin
          sw_d[i]      = sync2_q[i];
          dis_cnt_d[i] = 2'd0;
        end else begin
          dis_cnt_d[i] = dis_cnt_q[i] + 2'd1;
        end
      end
    end
    rise_d = sw_d & ~sw_q;

    for (int k = 0; k < NUM_HEX; k++) begin
      if (hex_en_i[k] && !(hex_blink_i[k] && phase_q)) begin
        hex_d[7*k +: 7] = seg_lut(hex_val_i[4*k +: 4]);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      sw_q      <= '0;
      rise_q    <= '0;
      dis_cnt_q <= '0;
      db_cnt_q  <= '0;
      bl_cnt_q  <= '0;
      phase_q   <= 1'b0;
      hex_q     <= '1;
      core_q    <= '0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sw_q      <= sw_d;
      rise_q    <= rise_d;
      dis_cnt_q <= dis_cnt_d;
      db_cnt_q  <= db_cnt_d;
      bl_cnt_q  <= bl_cnt_d;
      phase_q   <= phase_d;
      hex_q     <= hex_d;
      core_q    <= core_d;
    end
  end

  assign sw_o        = sw_q;
  assign sw_rise_o   = rise_q;
  assign hex_o       = hex_q;
  assign core_rst_no = core_q[1];

endmodule

// File: tb/tb_board_io_ctrl.sv
// tb/tb_board_io_ctrl.sv - randomized self-checking bench for board_io_ctrl
module tb_board_io_ctrl;
  localparam int NSW = 2;
  localparam int NHX = 2;
  localparam int DBC = 4;
  localparam int BLC = 8;
  // Active-high lit segments (g..a) for 0..F.
  localparam logic [6:0] SEG_ON [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NSW-1:0]   sw_raw = '0;
  logic [NSW-1:0]   sw, sw_rise;
  logic [4*NHX-1:0] hex_val = '0;
  logic [NHX-1:0]   hex_en = '0;
  logic [NHX-1:0]   hex_blink = '0;
  logic [7*NHX-1:0] hex;
  logic             core_rst_n;

  always #5 clk = ~clk;

  board_io_ctrl #(.NUM_SW(NSW), .NUM_HEX(NHX), .DEBOUNCE_CYC(DBC), .BLINK_CYC(BLC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .sw_raw_i(sw_raw), .sw_o(sw), .sw_rise_o(sw_rise),
    .hex_val_i(hex_val), .hex_en_i(hex_en), .hex_blink_i(hex_blink), .hex_o(hex),
    .core_rst_no(core_rst_n)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: cycle n counts clock edges since reset release.
  int n;
  logic [NSW-1:0]   raw_h1, raw_h2, m_sw, m_sw_prev;
  int               streak [NSW];
  logic [7*NHX-1:0] m_hex;

  task automatic model_reset();
    n = 0; raw_h1 = '0; raw_h2 = '0; m_sw = '0; m_sw_prev = '0; m_hex = '1;
    for (int i = 0; i < NSW; i++) streak[i] = 0;
  endtask

  task automatic cycle(input logic [NSW-1:0] raw, input logic [4*NHX-1:0] v,
                       input logic [NHX-1:0] en, input logic [NHX-1:0] bl);
    logic [NSW-1:0] synced;
    logic phase;
    sw_raw = raw; hex_val = v; hex_en = en; hex_blink = bl;
    synced = raw_h2;
    m_sw_prev = m_sw;
    if (n % DBC == DBC - 1) begin
      for (int i = 0; i < NSW; i++) begin
        if (synced[i] == m_sw[i]) streak[i] = 0;
        else begin
          streak[i]++;
          if (streak[i] == 3) begin
            m_sw[i] = synced[i];
            streak[i] = 0;
          end
        end
      end
    end
    phase = ((n / BLC) % 2) == 1;
    for (int k = 0; k < NHX; k++) begin
      logic [3:0] nib;
      nib = v[4*k +: 4];
      m_hex[7*k +: 7] = (!en[k] || (bl[k] && phase)) ? 7'h7F : ~SEG_ON[nib];
    end
    raw_h2 = raw_h1; raw_h1 = raw;
    @(posedge clk); #1;
    n++;
    check("sw_o", 32'(sw), 32'(m_sw));
    check("sw_rise_o", 32'(sw_rise), 32'(m_sw & ~m_sw_prev));
    check("hex_o", 32'(hex), 32'(m_hex));
    check("core_rst_no", 32'(core_rst_n), 32'(n >= 2));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sw"}, 32'(sw), 32'h0);
    check({tag, "_rise"}, 32'(sw_rise), 32'h0);
    check({tag, "_hex"}, 32'(hex), 32'h3FFF);
    check({tag, "_core"}, 32'(core_rst_n), 32'h0);
  endtask

  initial begin
    int first_rise;
    int rise_cnt;
    int glitch_seen;
    int d1_changes;
    logic [6:0] d1_first;
    int hold;
    logic [NSW-1:0] r;

    repeat (3) @(posedge clk);
    #1 check_reset_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1 check_reset_outputs("release");

    // Steady switch 0 high, static F0 display.
    first_rise = -1; rise_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(2'b01, 8'hF0, 2'b11, 2'b00);
      if (c == 0) check("hex_F0", 32'(hex), 32'({7'b0001110, 7'b1000000}));
      if (sw_rise[0]) begin
        rise_cnt++;
        if (first_rise < 0) first_rise = n;
      end
    end
    // Sync valid from cycle 2; ticks at cycles 3,7,11; output visible at cycle 12.
    check("sw0_rise_cycle", 32'(first_rise), 32'd12);
    check("sw0_rise_count", 32'(rise_cnt), 32'd1);

    // Switch 1: one-tick glitch, then two ticks high, then low: never accepted.
    glitch_seen = 0;
    for (int c = 0; c < 40; c++) begin
      logic b;
      b = (c >= 4 && c < 8) || (c >= 16 && c < 24);
      cycle({b, 1'b1}, 8'hF0, 2'b11, 2'b00);
      if (sw[1] || sw_rise[1]) glitch_seen++;
    end
    check("sw1_glitch", 32'(glitch_seen), 32'd0);

    // Blink digit 0 only; digit 1 must stay constant.
    d1_changes = 0;
    d1_first = '0;
    for (int c = 0; c < 40; c++) begin
      cycle(2'b01, 8'h5A, 2'b11, 2'b01);
      if (c == 0) d1_first = hex[13:7];
      else if (hex[13:7] != d1_first) d1_changes++;
    end
    check("digit1_steady", 32'(d1_changes), 32'd0);

    // Randomized traffic with held switch levels.
    hold = 0;
    r = '0;
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        r = NSW'($urandom);
        hold = $urandom_range(1, 20);
      end
      hold--;
      cycle(r, 8'($urandom), 2'($urandom), 2'($urandom));
    end

    // Get sw0 high, then start debouncing it back low, and reset mid-way.
    for (int c = 0; c < 24; c++) cycle(2'b01, 8'h12, 2'b11, 2'b00);
    for (int c = 0; c < 11; c++) cycle(2'b00, 8'h12, 2'b11, 2'b00);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_assert");
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("held");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1 check_reset_outputs("re_release");
    rise_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      cycle(2'b00, 8'h3C, 2'b10, 2'b00);
      if (sw_rise != 0) rise_cnt++;
    end
    check("no_rise_after_reset", 32'(rise_cnt), 32'd0);
    for (int c = 0; c < 30; c++) cycle(2'b11, 8'h3C, 2'b11, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1);
  end
endmodule
